// File: rtl/feed_scheduler.sv
// Pet-feeder scheduler: programmable time slots plus manual feeds drive a
// dispense/cooldown FSM, and a sequencer writes a new time into the clock.

module feed_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] cfg_hour,
  input  logic [7:0] cfg_min,
  input  logic [7:0] cfg_portion,
  input  logic       cfg_ampm,
  input  logic       cfg_en,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic       ampm,
  output logic       hit,
  output logic [7:0] portion
);
  logic [7:0] s_hour, s_min;
  logic       s_ampm, s_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_hour  <= '0;
      s_min   <= '0;
      s_ampm  <= 1'b0;
      s_en    <= 1'b0;
      portion <= '0;
    end else if (we) begin
      s_hour  <= cfg_hour;
      s_min   <= cfg_min;
      s_ampm  <= cfg_ampm;
      s_en    <= cfg_en;
      portion <= cfg_portion;
    end
  end

  assign hit = s_en && (portion != 8'd0) && (s_hour == hour) &&
               (s_min == minute) && (s_ampm == ampm);
endmodule

module feed_scheduler #(
  parameter int         NUM_SLOTS      = 4,
  parameter logic [7:0] MAX_PORTION    = 8'd30,
  parameter logic [7:0] MANUAL_PORTION = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       ampm,
  input  logic       cfg_we,
  input  logic [1:0] cfg_slot,
  input  logic [7:0] cfg_hour,
  input  logic [7:0] cfg_min,
  input  logic [7:0] cfg_portion,
  input  logic       cfg_ampm,
  input  logic       cfg_en,
  input  logic       manual_req,
  input  logic       set_req,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic       set_ampm,
  output logic       writeHour,
  output logic       writeMin,
  output logic       writeAmpm,
  output logic [7:0] data,
  output logic       set_busy,
  output logic       motor_on,
  output logic [1:0] feed_state,
  output logic [7:0] feed_count,
  output logic [2:0] last_src
);
  typedef enum logic [1:0] {F_IDLE = 2'd0, F_DISP = 2'd1, F_COOL = 2'd2} feed_t;
  typedef enum logic [1:0] {S_IDLE, S_HOUR, S_MIN, S_AMPM} seq_t;

  // ---------------- second tick ----------------
  logic [7:0] sec_q;
  logic       sec_vld;
  logic       tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q   <= '0;
      sec_vld <= 1'b0;
    end else begin
      sec_q   <= second;
      sec_vld <= 1'b1;
    end
  end

  assign tick = sec_vld && (second != sec_q);

  // ---------------- slots ----------------
  logic                       cfg_ok;
  logic [7:0]                 cfg_clamp;
  logic [NUM_SLOTS-1:0]       hit;
  logic [NUM_SLOTS-1:0][7:0]  portion;

  assign cfg_ok    = (cfg_hour >= 8'd1) && (cfg_hour <= 8'd12) && (cfg_min <= 8'd59);
  assign cfg_clamp = (cfg_portion > MAX_PORTION) ? MAX_PORTION : cfg_portion;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    feed_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .we         (cfg_we && cfg_ok && (cfg_slot == 2'(i))),
      .cfg_hour   (cfg_hour),
      .cfg_min    (cfg_min),
      .cfg_portion(cfg_clamp),
      .cfg_ampm   (cfg_ampm),
      .cfg_en     (cfg_en),
      .hour       (hour),
      .minute     (minute),
      .ampm       (ampm),
      .hit        (hit[i]),
      .portion    (portion[i])
    );
  end

  // Lowest index wins: scan downward so the last assignment is the lowest hit.
  logic       win_vld;
  logic [2:0] win_idx;
  logic [7:0] win_portion;

  always_comb begin
    win_vld     = 1'b0;
    win_idx     = '0;
    win_portion = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_vld     = 1'b1;
        win_idx     = 3'(i);
        win_portion = portion[i];
      end
    end
  end

  // ---------------- feed FSM ----------------
  feed_t      fstate, fnext;
  logic [7:0] remaining;
  logic       start, done, match_ok;
  logic [7:0] start_portion;
  logic [2:0] start_src;

  assign match_ok = tick && (second == 8'd0) && !set_busy && (fstate == F_IDLE) && win_vld;

  always_comb begin
    fnext         = fstate;
    start         = 1'b0;
    done          = 1'b0;
    start_portion = MANUAL_PORTION;
    start_src     = 3'd7;
    case (fstate)
      F_IDLE: begin
        if (match_ok) begin
          fnext         = F_DISP;
          start         = 1'b1;
          start_portion = win_portion;
          start_src     = win_idx;
        end else if (manual_req) begin
          fnext = F_DISP;
          start = 1'b1;
        end
      end
      F_DISP: if (tick && (remaining <= 8'd1)) begin
        fnext = F_COOL;
        done  = 1'b1;
      end
      F_COOL: if (tick) fnext = F_IDLE;
      default: fnext = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate     <= F_IDLE;
      remaining  <= '0;
      feed_count <= '0;
      last_src   <= '0;
    end else begin
      fstate <= fnext;
      if (start) begin
        remaining <= start_portion;
        last_src  <= start_src;
      end else if ((fstate == F_DISP) && tick) begin
        remaining <= remaining - 8'd1;
      end
      if (done && (feed_count != 8'hFF)) feed_count <= feed_count + 8'd1;
    end
  end

  assign feed_state = fstate;
  assign motor_on   = (fstate == F_DISP);

  // ---------------- time-set sequencer ----------------
  // Each strobe is held two cycles so a write swallowed by a clock rollover is repeated.
  seq_t       sstate, snext;
  logic       phase, cap;
  logic [7:0] cap_hour, cap_min;
  logic       cap_ampm;

  always_comb begin
    snext = sstate;
    cap   = 1'b0;
    case (sstate)
      S_IDLE: if (set_req) begin
        snext = S_HOUR;
        cap   = 1'b1;
      end
      S_HOUR:  if (phase) snext = S_MIN;
      S_MIN:   if (phase) snext = S_AMPM;
      S_AMPM:  if (phase) snext = S_IDLE;
      default: snext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sstate   <= S_IDLE;
      phase    <= 1'b0;
      cap_hour <= '0;
      cap_min  <= '0;
      cap_ampm <= 1'b0;
    end else begin
      sstate <= snext;
      phase  <= (sstate != S_IDLE) ? ~phase : 1'b0;
      if (cap) begin
        cap_hour <= set_hour;
        cap_min  <= set_min;
        cap_ampm <= set_ampm;
      end
    end
  end

  assign set_busy  = (sstate != S_IDLE);
  assign writeHour = (sstate == S_HOUR);
  assign writeMin  = (sstate == S_MIN);
  assign writeAmpm = (sstate == S_AMPM);

  always_comb begin
    data = '0;
    case (sstate)
      S_HOUR:  data = cap_hour;
      S_MIN:   data = cap_min;
      S_AMPM:  data = {7'b0, cap_ampm};
      default: data = '0;
    endcase
  end
endmodule

// File: tb/tb_feed_scheduler.sv
// Bench for feed_scheduler: directed scenarios, a table for the time-set
// sequence, and random traffic checked against a transaction-level model.

module tb_feed_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hour, minute, second;
  logic       ampm;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic [7:0] cfg_hour, cfg_min, cfg_portion;
  logic       cfg_ampm, cfg_en;
  logic       manual_req, set_req;
  logic [7:0] set_hour, set_min;
  logic       set_ampm;
  logic       writeHour, writeMin, writeAmpm;
  logic [7:0] data;
  logic       set_busy, motor_on;
  logic [1:0] feed_state;
  logic [7:0] feed_count;
  logic [2:0] last_src;

  int checks = 0;
  int passed = 0;

  feed_scheduler dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second), .ampm(ampm),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_hour(cfg_hour), .cfg_min(cfg_min),
    .cfg_portion(cfg_portion), .cfg_ampm(cfg_ampm), .cfg_en(cfg_en),
    .manual_req(manual_req), .set_req(set_req), .set_hour(set_hour), .set_min(set_min),
    .set_ampm(set_ampm), .writeHour(writeHour), .writeMin(writeMin), .writeAmpm(writeAmpm),
    .data(data), .set_busy(set_busy), .motor_on(motor_on), .feed_state(feed_state),
    .feed_count(feed_count), .last_src(last_src)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_fs, m_rem, m_cnt, m_src, m_prev, m_left, m_ch, m_cm, m_ca;
  bit m_hist;
  int s_en[4], s_h[4], s_m[4], s_a[4], s_p[4];

  function automatic void model_step();
    bit tk;
    int win;
    win = -1;
    if (reset) begin
      m_fs = 0; m_rem = 0; m_cnt = 0; m_src = 0; m_prev = 0; m_hist = 0;
      m_left = 0; m_ch = 0; m_cm = 0; m_ca = 0;
      for (int i = 0; i < 4; i++) begin
        s_en[i] = 0; s_h[i] = 0; s_m[i] = 0; s_a[i] = 0; s_p[i] = 0;
      end
      return;
    end
    tk = m_hist && (int'(second) != m_prev);
    if (tk && second == 8'd0 && m_left == 0 && m_fs == 0)
      for (int i = 3; i >= 0; i--)
        if (s_en[i] != 0 && s_p[i] != 0 && s_h[i] == int'(hour) &&
            s_m[i] == int'(minute) && s_a[i] == int'(ampm)) win = i;
    case (m_fs)
      0: if (win >= 0) begin m_fs = 1; m_rem = s_p[win]; m_src = win; end
         else if (manual_req) begin m_fs = 1; m_rem = 5; m_src = 7; end
      1: if (tk) begin
           m_rem--;
           if (m_rem <= 0) begin m_fs = 2; if (m_cnt < 255) m_cnt++; end
         end
      default: if (tk) m_fs = 0;
    endcase
    if (m_left > 0) m_left--;
    else if (set_req) begin
      m_left = 6; m_ch = int'(set_hour); m_cm = int'(set_min); m_ca = int'(set_ampm);
    end
    if (cfg_we && cfg_hour >= 8'd1 && cfg_hour <= 8'd12 && cfg_min <= 8'd59) begin
      s_en[cfg_slot] = int'(cfg_en); s_h[cfg_slot] = int'(cfg_hour);
      s_m[cfg_slot] = int'(cfg_min); s_a[cfg_slot] = int'(cfg_ampm);
      s_p[cfg_slot] = (cfg_portion > 8'd30) ? 30 : int'(cfg_portion);
    end
    m_prev = int'(second);
    m_hist = 1;
  endfunction

  function automatic logic [31:0] exp_bundle();
    logic wh, wm, wa;
    logic [7:0] d;
    wh = 0; wm = 0; wa = 0; d = '0;
    if (m_left > 0)
      case ((6 - m_left) / 2)
        0: begin wh = 1; d = 8'(m_ch); end
        1: begin wm = 1; d = 8'(m_cm); end
        default: begin wa = 1; d = 8'(m_ca); end
      endcase
    return {6'b0, wh, wm, wa, d, m_left > 0, m_fs == 1, 2'(m_fs), 8'(m_cnt), 3'(m_src)};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", {6'b0, writeHour, writeMin, writeAmpm, data, set_busy, motor_on,
                    feed_state, feed_count, last_src}, exp_bundle());
  endtask

  // one second step: tick cycle plus one quiet cycle
  task automatic adv();
    second = (second == 8'd59) ? 8'd0 : second + 8'd1;
    cyc();
    cyc();
  endtask

  task automatic write_slot(input logic [1:0] s, input logic [7:0] h, input logic [7:0] m,
                            input logic a, input logic [7:0] p, input logic e);
    cfg_we = 1; cfg_slot = s; cfg_hour = h; cfg_min = m; cfg_ampm = a; cfg_portion = p; cfg_en = e;
    cyc();
    cfg_we = 0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic a);
    hour = h; minute = m; ampm = a; second = 8'd59;
    cyc();
    cyc();
  endtask

  typedef struct {
    bit       sreq;
    bit [7:0] sh, sm;
    bit       sa;
    bit [7:0] sec;
    bit [2:0] strb;
    bit [7:0] d;
    bit       busy;
    bit [1:0] fs;
  } vec_t;
  vec_t tbl[7];

  bit [7:0] cfg_hl[4];
  bit [7:0] cfg_ml[3];
  int n;

  initial begin
    tbl = '{
      '{1'b1, 8'd10, 8'd45, 1'b1, 8'd59, 3'b100, 8'd10, 1'b1, 2'd0},
      '{1'b1, 8'd3,  8'd3,  1'b0, 8'd59, 3'b100, 8'd10, 1'b1, 2'd0},
      '{1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  3'b010, 8'd45, 1'b1, 2'd0},
      '{1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  3'b010, 8'd45, 1'b1, 2'd0},
      '{1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  3'b001, 8'd1,  1'b1, 2'd0},
      '{1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  3'b001, 8'd1,  1'b1, 2'd0},
      '{1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  3'b000, 8'd0,  1'b0, 2'd0}
    };
    cfg_hl = '{8'd7, 8'd8, 8'd13, 8'd0};
    cfg_ml = '{8'd0, 8'd30, 8'd60};

    reset = 1; hour = 0; minute = 0; second = 0; ampm = 0;
    cfg_we = 0; cfg_slot = 0; cfg_hour = 0; cfg_min = 0; cfg_portion = 0; cfg_ampm = 0; cfg_en = 0;
    manual_req = 0; set_req = 0; set_hour = 0; set_min = 0; set_ampm = 0;
    cyc();
    cyc();
    check("reset outputs", {writeHour, writeMin, writeAmpm, data, set_busy, motor_on,
                            feed_state, feed_count, last_src}, 32'd0);
    reset = 0;
    cyc();

    // scheduled feed from slot 1, 7:30 PM, 3 ticks
    write_slot(2'd1, 8'd7, 8'd30, 1'b1, 8'd3, 1'b1);
    set_time(8'd7, 8'd30, 1'b1);
    adv();
    check("s1 start state", feed_state, 1);
    check("s1 motor", motor_on, 1);
    check("s1 src", last_src, 1);
    adv(); adv();
    check("s1 still dispensing", feed_state, 1);
    adv();
    check("s1 cooldown", {motor_on, feed_state}, {1'b0, 2'd2});
    check("s1 count", feed_count, 1);
    adv();
    check("s1 idle", feed_state, 0);

    // slots 0 and 2 collide at 8:00 AM: slot 0 wins
    write_slot(2'd0, 8'd8, 8'd0, 1'b0, 8'd2, 1'b1);
    write_slot(2'd2, 8'd8, 8'd0, 1'b0, 8'd2, 1'b1);
    set_time(8'd8, 8'd0, 1'b0);
    adv();
    check("prio src", last_src, 0);
    adv(); adv();
    check("prio count", feed_count, 2);
    adv();

    // invalid writes ignored, oversize portion clamped
    write_slot(2'd3, 8'd13, 8'd0, 1'b0, 8'd5, 1'b1);
    set_time(8'd13, 8'd0, 1'b0);
    adv();
    check("hour13 ignored", feed_state, 0);
    write_slot(2'd3, 8'd12, 8'd60, 1'b0, 8'd5, 1'b1);
    set_time(8'd12, 8'd60, 1'b0);
    adv();
    check("min60 ignored", feed_state, 0);
    write_slot(2'd3, 8'd9, 8'd15, 1'b1, 8'd200, 1'b1);
    set_time(8'd9, 8'd15, 1'b1);
    adv();
    check("clamp start", {feed_state, last_src}, {2'd1, 3'd3});
    n = 0;
    while (feed_state == 2'd1 && n < 40) begin adv(); n++; end
    check("clamp ticks", n, 30);
    adv();

    // time-set sequence; a slot match in the window is dropped
    set_time(8'd8, 8'd0, 1'b0);
    foreach (tbl[i]) begin
      set_req = tbl[i].sreq; set_hour = tbl[i].sh; set_min = tbl[i].sm; set_ampm = tbl[i].sa;
      second = tbl[i].sec;
      cyc();
      check($sformatf("set row%0d", i), {writeHour, writeMin, writeAmpm, data, set_busy, feed_state},
            {tbl[i].strb, tbl[i].d, tbl[i].busy, tbl[i].fs});
    end
    set_req = 0;

    // manual feed, manual during dispense ignored, reset mid-dispense
    manual_req = 1;
    cyc();
    manual_req = 0;
    check("manual start", {feed_state, last_src}, {2'd1, 3'd7});
    adv();
    manual_req = 1;
    cyc();
    manual_req = 0;
    n = 1;
    while (feed_state == 2'd1 && n < 20) begin adv(); n++; end
    check("manual ticks", n, 5);
    check("manual count", feed_count, 4);
    adv();
    manual_req = 1;
    cyc();
    manual_req = 0;
    adv();
    second = second + 8'd1;
    reset = 1;
    cyc();
    check("reset mid feed", {motor_on, feed_state, feed_count}, 11'd0);
    reset = 0;
    cyc();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 499) == 0);
      cfg_we      = ($urandom_range(0, 29) == 0);
      cfg_slot    = 2'($urandom);
      cfg_hour    = cfg_hl[$urandom_range(0, 3)];
      cfg_min     = cfg_ml[$urandom_range(0, 2)];
      cfg_ampm    = 1'($urandom);
      cfg_portion = 8'($urandom_range(0, 40));
      cfg_en      = ($urandom_range(0, 3) != 0);
      manual_req  = ($urandom_range(0, 39) == 0);
      set_req     = ($urandom_range(0, 59) == 0);
      set_hour    = 8'($urandom);
      set_min     = 8'($urandom);
      set_ampm    = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        if (second >= 8'd59) begin
          second = 0;
          hour   = ($urandom_range(0, 1) == 1) ? 8'd7 : 8'd8;
          minute = ($urandom_range(0, 1) == 1) ? 8'd30 : 8'd0;
          ampm   = 1'($urandom);
        end else second = second + 8'd1;
      end
      if ($urandom_range(0, 49) == 0) second = 8'd59;
      cyc();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/feed_scheduler.md
FEED_SCHEDULER -- requirements
Module: feed_scheduler

Interface
REQ-001 Parameters (name, default, meaning): NUM_SLOTS, 4, programmable feed slots; MAX_PORTION, 8'd30, dispense-seconds clamp; MANUAL_PORTION, 8'd5, seconds per manual feed.
REQ-002 clk  in  1  system clock, same domain as the time-of-day clock.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 hour, minute, second  in  8 each  current time from the time-of-day clock (hour 1..12).
REQ-005 ampm  in  1  current AM/PM bit from the clock.
REQ-006 cfg_we  in  1  slot write strobe; cfg_slot  in  2  slot index; cfg_hour, cfg_min, cfg_portion  in  8 each; cfg_ampm, cfg_en  in  1 each.
REQ-007 manual_req  in  1  manual feed request, level or pulse.
REQ-008 set_req  in  1  time-set request; set_hour, set_min  in  8 each; set_ampm  in  1.
REQ-009 writeHour, writeMin, writeAmpm  out  1 each; data  out  8  write port driving the clock.
REQ-010 set_busy  out  1  time-set sequence in progress.
REQ-011 motor_on  out  1  dispenser drive; feed_state  out  2  (0 IDLE, 1 DISPENSE, 2 COOLDOWN); feed_count  out  8  completed feeds; last_src  out  3  source of last feed (slot index 0..3, 7 = manual).

Function
REQ-012 Tick: the block SHALL register second each cycle; tick = 1 for one cycle when second differs from its registered value; no tick on the first cycle after reset.
REQ-013 Slot write: on cfg_we, slot[cfg_slot] SHALL load all cfg fields only if 1<=cfg_hour<=12 and cfg_min<=59; otherwise the write is ignored and the slot is unchanged.
REQ-014 Stored portion SHALL be min(cfg_portion, MAX_PORTION).
REQ-015 Match: on a tick with second==0, set_busy==0 and feed_state==IDLE, a slot matches if enabled, portion!=0, and hour/minute/ampm equal the inputs; the lowest-index matching slot wins, the others are dropped.
REQ-016 Manual: manual_req high in IDLE on a cycle with no slot match SHALL start a feed with MANUAL_PORTION; a slot match on the same cycle takes priority and manual_req is ignored.
REQ-017 A feed start SHALL, on the next cycle, set feed_state=DISPENSE, motor_on=1, remaining=portion, and last_src=source.
REQ-018 DISPENSE: each tick decrements remaining; the tick that reaches 0 SHALL move to COOLDOWN on the next cycle with motor_on=0, and feed_count increments (saturating at 255).
REQ-019 COOLDOWN: the next tick SHALL return to IDLE; requests and matches during DISPENSE/COOLDOWN are discarded, not queued.
REQ-020 motor_on SHALL be 1 exactly while feed_state==DISPENSE.
REQ-021 Set sequencer states: S_IDLE, S_HOUR, S_MIN, S_AMPM. When set_req is high in S_IDLE, set_hour/set_min/set_ampm SHALL be captured and the sequencer SHALL enter S_HOUR.
REQ-022 Each of S_HOUR, S_MIN, S_AMPM SHALL last exactly 2 cycles, asserting only its strobe (writeHour, writeMin, writeAmpm) with data = captured hour, captured minute, or {7'b0, ampm}, so that a write lost on the clock's rollover cycle is repeated.
REQ-023 The set sequence is 6 cycles in total; set_busy=1 throughout; set_req while busy is ignored.
REQ-024 A set sequence SHALL NOT interrupt an active feed.
REQ-025 Strobes SHALL be 0 and data SHALL be 0 outside the set sequence.

Reset
REQ-026 Reset SHALL force feed_state=IDLE, motor_on=0, feed_count=0, last_src=0, set sequencer S_IDLE, all strobes and data 0, set_busy=0, all slots disabled with fields 0, and clear the tick history.
REQ-027 Reset mid-DISPENSE or mid-set SHALL drop motor_on and the strobes on the next cycle, with no partial completion counted.

Verification
REQ-028 Program slot 1 with 7:30 PM, portion 3, enabled; drive time 7:30:00 PM -> DISPENSE with motor_on=1 for 3 ticks, then COOLDOWN for 1 tick, then IDLE; feed_count=1; last_src=1.
REQ-029 Slots 0 and 2 both match 8:00 AM -> only slot 0 feeds (last_src=0); feed_count rises by 1.
REQ-030 cfg_hour=13 or cfg_min=60 write -> slot unchanged; cfg_portion=200 -> dispense lasts 30 ticks.
REQ-031 set_req with 10/45/1 -> writeHour for 2 cycles with data=10, then writeMin for 2 cycles with data=45, then writeAmpm for 2 cycles with data=1; set_busy high for 6 cycles; a match during this window is ignored.
REQ-032 manual_req during DISPENSE -> ignored; manual_req in IDLE -> 5-tick feed with last_src=7; reset asserted at the second dispense tick -> motor_on=0 next cycle, feed_count=0.
